// File: rtl/fpmul_dual_requester_pkg.sv
// Shared definitions for the dual FP32 multiplier requester: FSM encoding and result tag meaning.
package fpmul_dual_requester_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // res_rdy tag values driven by the multiplier top
    localparam logic [TAG_W-1:0] RDY_NONE = 2'b00;
    localparam logic [TAG_W-1:0] RDY_VHDL = 2'b01;
    localparam logic [TAG_W-1:0] RDY_VLOG = 2'b10;
    localparam logic [TAG_W-1:0] RDY_BAD  = 2'b11;

endpackage

// File: rtl/fpmul_tag_capture.sv
// Detects new result tags on the level-held res_rdy bus and captures each core's product once per job.
module fpmul_tag_capture
    import fpmul_dual_requester_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr_res,
    input  logic              i_clr_got,
    input  logic              i_arm,
    input  logic              i_en,
    input  logic [TAG_W-1:0]  i_res_rdy,
    input  logic [DATA_W-1:0] i_res,
    output logic              o_got_vlog_c,
    output logic              o_got_vhdl_c,
    output logic [DATA_W-1:0] o_res_vlog_c,
    output logic [DATA_W-1:0] o_res_vhdl_c,
    output logic [DATA_W-1:0] o_res_vlog,
    output logic [DATA_W-1:0] o_res_vhdl
);

    logic [TAG_W-1:0]  r_rr_prev;
    logic              r_got_vlog;
    logic              r_got_vhdl;
    logic [DATA_W-1:0] r_res_vlog;
    logic [DATA_W-1:0] r_res_vhdl;

    logic w_new_tag;
    logic w_cap_vlog;
    logic w_cap_vhdl;

    // A tag only counts when it differs from the previous level; 2'b11 is never a legal tag
    always_comb begin
        w_new_tag    = i_en && (i_res_rdy != r_rr_prev) && (i_res_rdy != RDY_NONE)
                       && (i_res_rdy != RDY_BAD);
        w_cap_vlog   = w_new_tag && (i_res_rdy == RDY_VLOG) && !r_got_vlog;
        w_cap_vhdl   = w_new_tag && (i_res_rdy == RDY_VHDL) && !r_got_vhdl;
        o_got_vlog_c = r_got_vlog | w_cap_vlog;
        o_got_vhdl_c = r_got_vhdl | w_cap_vhdl;
        o_res_vlog_c = w_cap_vlog ? i_res : r_res_vlog;
        o_res_vhdl_c = w_cap_vhdl ? i_res : r_res_vhdl;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_prev  <= RDY_NONE;
            r_got_vlog <= 1'b0;
            r_got_vhdl <= 1'b0;
            r_res_vlog <= '0;
            r_res_vhdl <= '0;
        end else begin
            if (i_arm) begin
                r_rr_prev <= i_res_rdy;
            end else if (i_en && (i_res_rdy != RDY_BAD)) begin
                r_rr_prev <= i_res_rdy;
            end

            if (i_clr_got) begin
                r_got_vlog <= 1'b0;
                r_got_vhdl <= 1'b0;
            end else begin
                r_got_vlog <= o_got_vlog_c;
                r_got_vhdl <= o_got_vhdl_c;
            end

            if (i_clr_res) begin
                r_res_vlog <= '0;
                r_res_vhdl <= '0;
            end else begin
                r_res_vlog <= o_res_vlog_c;
                r_res_vhdl <= o_res_vhdl_c;
            end
        end
    end

    assign o_res_vlog = r_res_vlog;
    assign o_res_vhdl = r_res_vhdl;

endmodule

// File: rtl/fpmul_dual_requester.sv
// Issues one operand pair to both multiplier cores, collects both tagged results and reports
// the pair with mismatch and timeout flags.
module fpmul_dual_requester
    import fpmul_dual_requester_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_op1,
    input  logic [DATA_W-1:0] s_op2,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    output logic [TAG_W-1:0]  in_rdy,
    input  logic [DATA_W-1:0] res,
    input  logic [TAG_W-1:0]  res_rdy,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_res_vlog,
    output logic [DATA_W-1:0] m_res_vhdl,
    output logic              m_mismatch,
    output logic              m_timeout
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic              r_mismatch;
    logic              r_timeout;

    logic              w_accept;
    logic              w_expire;
    logic              w_both;
    logic              w_wait_end;
    logic              w_leave;
    logic              w_got_vlog;
    logic              w_got_vhdl;
    logic [DATA_W-1:0] w_vlog_nxt;
    logic [DATA_W-1:0] w_vhdl_nxt;

    always_comb begin
        w_accept   = s_valid && (r_state == ST_IDLE);
        w_expire   = (r_cnt == CNT_W'(TIMEOUT - 1));
        w_both     = w_got_vlog && w_got_vhdl;
        w_wait_end = (r_state == ST_WAIT) && (w_both || w_expire);
        w_leave    = (r_state == ST_DONE) && m_ready;
    end

    fpmul_tag_capture u_capture (
        .clk          (clk),
        .rst          (rst),
        .i_clr_res    (w_accept),
        .i_clr_got    (w_leave),
        .i_arm        (r_state == ST_ISSUE),
        .i_en         (r_state == ST_WAIT),
        .i_res_rdy    (res_rdy),
        .i_res        (res),
        .o_got_vlog_c (w_got_vlog),
        .o_got_vhdl_c (w_got_vhdl),
        .o_res_vlog_c (w_vlog_nxt),
        .o_res_vhdl_c (w_vhdl_nxt),
        .o_res_vlog   (m_res_vlog),
        .o_res_vhdl   (m_res_vhdl)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)   w_state_nxt = ST_ISSUE;
            ST_ISSUE:                 w_state_nxt = ST_WAIT;
            ST_WAIT:  if (w_wait_end) w_state_nxt = ST_DONE;
            ST_DONE:  if (w_leave)    w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        s_ready = 1'b0;
        in_rdy  = 2'b00;
        m_valid = 1'b0;
        case (r_state)
            ST_IDLE:  s_ready = 1'b1;
            ST_ISSUE: in_rdy  = 2'b11;
            ST_DONE:  m_valid = 1'b1;
            default:  ;
        endcase
    end

    // Operand latch, timeout counter and result flags (frozen for the whole DONE state)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op1      <= '0;
            r_op2      <= '0;
            r_cnt      <= '0;
            r_mismatch <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op1 <= s_op1;
                r_op2 <= s_op2;
            end

            if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_leave) begin
                r_cnt <= '0;
            end

            if (w_wait_end) begin
                r_mismatch <= w_both && (w_vlog_nxt != w_vhdl_nxt);
                r_timeout  <= !w_both;
            end else if (w_leave) begin
                r_mismatch <= 1'b0;
                r_timeout  <= 1'b0;
            end
        end
    end

    assign op1        = r_op1;
    assign op2        = r_op2;
    assign m_mismatch = r_mismatch;
    assign m_timeout  = r_timeout;

endmodule

// File: tb/tb_fpmul_dual_requester.sv
// Directed bench for fpmul_dual_requester: tag ordering, mismatch, stale tags, timeout and reset.
module tb_fpmul_dual_requester;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_op1;
    logic [31:0] s_op2;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  in_rdy;
    logic [31:0] res;
    logic [1:0]  res_rdy;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_res_vlog;
    logic [31:0] m_res_vhdl;
    logic        m_mismatch;
    logic        m_timeout;

    int checks = 0;
    int errors = 0;

    fpmul_dual_requester #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_op1      (s_op1),
        .s_op2      (s_op2),
        .op1        (op1),
        .op2        (op2),
        .in_rdy     (in_rdy),
        .res        (res),
        .res_rdy    (res_rdy),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_res_vlog (m_res_vlog),
        .m_res_vhdl (m_res_vhdl),
        .m_mismatch (m_mismatch),
        .m_timeout  (m_timeout)
    );

    always #5 clk = ~clk;

    // Handshake one operand pair; returns at the negedge where the DUT is in ISSUE
    task automatic go_job(input logic [31:0] a, input logic [31:0] b);
        s_valid = 1'b1;
        s_op1   = a;
        s_op2   = b;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic accept();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; s_valid = 1'b0; s_op1 = '0; s_op2 = '0;
        res = '0; res_rdy = 2'b00; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        checks++; if (in_rdy !== 2'b00) begin errors++; $display("FAIL reset_in_rdy got %b want 00", in_rdy); end
        checks++; if ({op1, op2} !== 64'h0) begin errors++; $display("FAIL reset_ops got %h want 0", {op1, op2}); end
        checks++; if ({m_res_vlog, m_res_vhdl, m_mismatch, m_timeout} !== 66'h0) begin
            errors++; $display("FAIL reset_results got %h want 0", {m_res_vlog, m_res_vhdl, m_mismatch, m_timeout}); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
    endtask

    task automatic test_basic();
        res_rdy = 2'b00;
        go_job(32'h40000000, 32'h40400000);
        checks++; if (in_rdy !== 2'b11) begin errors++; $display("FAIL basic_in_rdy got %b want 11", in_rdy); end
        checks++; if (op1 !== 32'h40000000 || op2 !== 32'h40400000) begin
            errors++; $display("FAIL basic_ops got %h %h want 40000000 40400000", op1, op2); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL basic_s_ready_issue got %b want 0", s_ready); end
        @(negedge clk);
        checks++; if (in_rdy !== 2'b00) begin errors++; $display("FAIL basic_in_rdy_pulse got %b want 00", in_rdy); end
        res_rdy = 2'b01; res = 32'h40C00000;
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", m_valid); end
        res_rdy = 2'b10; res = 32'h40C00000;
        @(negedge clk);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL basic_m_valid got %b want 1", m_valid); end
        checks++; if (m_res_vlog !== 32'h40C00000 || m_res_vhdl !== 32'h40C00000) begin
            errors++; $display("FAIL basic_results got %h %h want 40c00000 40c00000", m_res_vlog, m_res_vhdl); end
        checks++; if (m_mismatch !== 1'b0 || m_timeout !== 1'b0) begin
            errors++; $display("FAIL basic_flags got %b%b want 00", m_mismatch, m_timeout); end
        accept();
        checks++; if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            errors++; $display("FAIL basic_return_idle got s_ready=%b m_valid=%b want 1 0", s_ready, m_valid); end
    endtask

    task automatic test_both_ready_order();
        res_rdy = 2'b00;
        go_job(32'h40000000, 32'h40400000);
        @(negedge clk);
        res_rdy = 2'b10; res = 32'h40C00000;
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL order_n1_valid got %b want 0", m_valid); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL order_s_ready_wait got %b want 0", s_ready); end
        res_rdy = 2'b01; res = 32'h40C00000;
        @(negedge clk);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL order_n2_valid got %b want 1", m_valid); end
        checks++; if (m_res_vlog !== 32'h40C00000 || m_res_vhdl !== 32'h40C00000) begin
            errors++; $display("FAIL order_results got %h %h want 40c00000 40c00000", m_res_vlog, m_res_vhdl); end
        accept();
    endtask

    task automatic test_mismatch();
        res_rdy = 2'b00;
        go_job(32'h40000000, 32'h40400000);
        @(negedge clk);
        res_rdy = 2'b01; res = 32'h40C00000;
        @(negedge clk);
        res_rdy = 2'b10; res = 32'h40C00001;
        @(negedge clk);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL mism_valid got %b want 1", m_valid); end
        checks++; if (m_res_vlog !== 32'h40C00001 || m_res_vhdl !== 32'h40C00000) begin
            errors++; $display("FAIL mism_results got %h %h want 40c00001 40c00000", m_res_vlog, m_res_vhdl); end
        checks++; if (m_mismatch !== 1'b1 || m_timeout !== 1'b0) begin
            errors++; $display("FAIL mism_flags got %b%b want 10", m_mismatch, m_timeout); end
        accept();
    endtask

    task automatic test_back_to_back();
        // res_rdy still 10 from the previous job
        go_job(32'h3F800000, 32'h40000000);
        @(negedge clk);
        res = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        checks++; if (m_res_vlog !== 32'h0 || m_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_stale_tag got vlog=%h valid=%b want 0 0", m_res_vlog, m_valid); end
        res_rdy = 2'b11;
        @(negedge clk);
        checks++; if (m_res_vlog !== 32'h0 || m_res_vhdl !== 32'h0) begin
            errors++; $display("FAIL b2b_illegal_tag got %h %h want 0 0", m_res_vlog, m_res_vhdl); end
        res_rdy = 2'b01; res = 32'h40000000;
        @(negedge clk);
        checks++; if (m_res_vhdl !== 32'h40000000 || m_res_vlog !== 32'h0) begin
            errors++; $display("FAIL b2b_vhdl_first got vhdl=%h vlog=%h want 40000000 0", m_res_vhdl, m_res_vlog); end
        res_rdy = 2'b10; res = 32'h40000000;
        @(negedge clk);
        checks++; if (m_valid !== 1'b1 || m_res_vlog !== 32'h40000000 || m_mismatch !== 1'b0) begin
            errors++; $display("FAIL b2b_done got valid=%b vlog=%h mism=%b want 1 40000000 0", m_valid, m_res_vlog, m_mismatch); end
        accept();
    endtask

    task automatic test_timeout();
        int n;
        res_rdy = 2'b00;
        go_job(32'h40000000, 32'h40400000);
        @(negedge clk);
        n = 1;
        res_rdy = 2'b01; res = 32'h40C00000;
        while (n <= 40) begin
            @(negedge clk);
            if (m_valid === 1'b1) break;
            n++;
        end
        checks++; if (n !== TO) begin errors++; $display("FAIL timeout_wait_cycles got %0d want %0d", n, TO); end
        checks++; if (m_valid !== 1'b1 || m_timeout !== 1'b1 || m_mismatch !== 1'b0) begin
            errors++; $display("FAIL timeout_flags got valid=%b to=%b mism=%b want 1 1 0", m_valid, m_timeout, m_mismatch); end
        checks++; if (m_res_vlog !== 32'h0 || m_res_vhdl !== 32'h40C00000) begin
            errors++; $display("FAIL timeout_results got %h %h want 0 40c00000", m_res_vlog, m_res_vhdl); end
        accept();
    endtask

    task automatic test_timeout_edge();
        int n;
        res_rdy = 2'b00;
        go_job(32'h40000000, 32'h40400000);
        @(negedge clk);
        n = 1;
        res_rdy = 2'b01; res = 32'h40C00000;
        repeat (TO - 1) begin
            @(negedge clk);
            n++;
        end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL tedge_early_valid got %b want 0", m_valid); end
        // Last WAIT cycle: the counter is at TIMEOUT-1 when this tag is sampled
        res_rdy = 2'b10; res = 32'h40C00000;
        @(negedge clk);
        checks++; if (m_valid !== 1'b1 || m_timeout !== 1'b0 || m_mismatch !== 1'b0) begin
            errors++; $display("FAIL tedge_flags got valid=%b to=%b mism=%b want 1 0 0", m_valid, m_timeout, m_mismatch); end
        checks++; if (m_res_vlog !== 32'h40C00000) begin
            errors++; $display("FAIL tedge_vlog got %h want 40c00000", m_res_vlog); end
        accept();
    endtask

    task automatic test_reset_midjob_and_hold();
        res_rdy = 2'b00;
        go_job(32'h40000000, 32'h40400000);
        @(negedge clk);
        res_rdy = 2'b01; res = 32'h12345678;
        @(negedge clk);
        checks++; if (m_res_vhdl !== 32'h12345678) begin
            errors++; $display("FAIL midrst_capture got %h want 12345678", m_res_vhdl); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({op1, m_res_vhdl, m_res_vlog} !== 96'h0 || in_rdy !== 2'b00 || m_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs got op1=%h vhdl=%h vlog=%h in_rdy=%b valid=%b want all 0",
                               op1, m_res_vhdl, m_res_vlog, in_rdy, m_valid); end
        @(negedge clk);
        rst = 1'b1; res_rdy = 2'b00;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL midrst_s_ready got %b want 1", s_ready); end
        go_job(32'h40400000, 32'h40400000);
        @(negedge clk);
        res_rdy = 2'b10; res = 32'h41100000;
        @(negedge clk);
        res_rdy = 2'b01; res = 32'h41100000;
        @(negedge clk);
        res = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            checks++; if (m_valid !== 1'b1 || m_res_vlog !== 32'h41100000 || m_res_vhdl !== 32'h41100000
                          || m_mismatch !== 1'b0 || m_timeout !== 1'b0) begin
                errors++; $display("FAIL hold_stable_%0d got valid=%b vlog=%h vhdl=%h mism=%b to=%b want 1 41100000 41100000 0 0",
                                   i, m_valid, m_res_vlog, m_res_vhdl, m_mismatch, m_timeout); end
            @(negedge clk);
        end
        accept();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL hold_release got s_ready=%b want 1", s_ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_both_ready_order();
        test_mismatch();
        test_back_to_back();
        test_timeout();
        test_timeout_edge();
        test_reset_midjob_and_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
